// File: rtl/spike_fifo_arbiter_if.sv
// Handshake bundle between spike producers / event FIFO and the round-robin write arbiter.
// SPIKE_ARB_STALL_CNT_EN adds the stall_cnt observation signal.
interface spike_fifo_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]             gnt;
    logic                           fifo_full;
    logic                           fifo_wr_en;
    logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wdata;
    logic                           busy;

`ifdef SPIKE_ARB_STALL_CNT_EN
    logic [15:0]                    stall_cnt;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_wdata, busy, stall_cnt
    );
    modport slave (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_wdata, busy, stall_cnt
    );
`else
    modport master (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_wdata, busy
    );
    modport slave (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_wdata, busy
    );
`endif
endinterface

// File: rtl/spike_fifo_arbiter.sv
// Round-robin arbiter: one tagged FIFO write per 2-cycle ARB/WR round, grant/write registered one edge after req.
// Backpressure: no round starts while fifo_full; SPIKE_ARB_STALL_CNT_EN adds a saturating stall counter.
module spike_fifo_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spike_fifo_arbiter_if.slave  bus
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam int WD_WIDTH = ID_WIDTH + DATA_WIDTH;

    typedef enum logic {ST_ARB, ST_WR} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_last;
    logic [ID_WIDTH-1:0]   w_last_nxt;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    w_gnt_nxt;
    logic [WD_WIDTH-1:0]   r_wdata;
    logic [WD_WIDTH-1:0]   w_wdata_nxt;
    logic                  r_wr_en;
    logic                  w_wr_en_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic [ID_WIDTH-1:0]   w_idx;
    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_found;

    // Search starts just after the previous winner and wraps at NUM_REQ-1.
    always_comb begin
        w_idx    = r_last;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + ID_WIDTH'(1);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_wr_en_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_wdata_nxt = r_wdata;
        w_last_nxt  = r_last;
        case (r_state)
            ST_ARB: begin
                if (w_found && !bus.fifo_full) begin
                    w_state_nxt = ST_WR;
                    w_gnt_nxt   = NUM_REQ'(1) << w_winner;
                    w_wr_en_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_wdata_nxt = {w_winner, bus.req_data[w_winner*DATA_WIDTH +: DATA_WIDTH]};
                    w_last_nxt  = w_winner;
                end
            end
            // The write commits on the edge leaving WR, so full is fresh on return to ARB.
            ST_WR:   w_state_nxt = ST_ARB;
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_wdata <= '0;
            r_last  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_busy  <= w_busy_nxt;
            r_wdata <= w_wdata_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.fifo_wr_en = r_wr_en;
    assign bus.fifo_wdata = r_wdata;
    assign bus.busy       = r_busy;

`ifdef SPIKE_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_ARB) && (|bus.req) && bus.fifo_full
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
